packed_pixel_reader: RTL and testbench
======================================

Name: packed_pixel_reader

Overview:
- Read-side counterpart of the CCD 1-bit pixel packer.
- The packer shifts binarised pixels in LSB-first and stores them 16 per word in SDRAM.
- This block pops those packed words from an SDRAM read-port FIFO and unpacks them into one pixel per VGA request.
- It sits between the SDRAM controller read port and the VGA controller colour inputs. It replaces the 1-word-per-pixel frame buffer, cutting its SDRAM bandwidth 16x.

Parameters:
WORD_WIDTH  16  pixels per packed word; must be a power of two
FRAME_PIXELS  307200  pixels per frame (640*480); must be a multiple of WORD_WIDTH
DATA_WIDTH  10  width of the expanded colour output

Ports:
iCLK  input  1  pixel clock; all logic on rising edge
iRST  input  1  synchronous active-high reset
iFRAME_START  input  1  one-cycle pulse; flush buffers and begin prefetch of a new frame
iREQUEST  input  1  VGA pixel request; one pixel consumed per cycle high
iFIFO_EMPTY  input  1  SDRAM read FIFO empty flag
oFIFO_RD  output  1  FIFO pop strobe; data returns one cycle later
iFIFO_DATA  input  WORD_WIDTH  packed word, valid the cycle after oFIFO_RD
oPIXEL  output  1  unpacked pixel
oDATA  output  DATA_WIDTH  {DATA_WIDTH{oPIXEL}} (white/black expansion)
oPIX_VALID  output  1  oPIXEL/oDATA valid this cycle
oFRAME_DONE  output  1  one-cycle pulse coincident with the last pixel of the frame
oUNDERRUN  output  1  sticky error flag; cleared by iRST or iFRAME_START
oPIX_COUNT  output  19  pixels delivered in current frame

Behaviour:
- Reset (iRST high at clock edge, overrides everything):
  - state IDLE; all outputs 0; buffers 0; bit index 0; no fetch pending.
- Internal storage:
  - cur word, plus bit index 0..WORD_WIDTH-1.
  - next word, with a next_valid flag.
  - fetch_pending flag (pop issued, data due next cycle).
- Bit order: pixel k of a word is bit k. Bit 0 is the first pixel in time.
- States:
  - IDLE: wait for iFRAME_START, then go to FILL.
  - FILL: prefetch two words.
    - oFIFO_RD is asserted only when !iFIFO_EMPTY and no fetch is pending.
    - The first returned word loads cur; the second loads next and sets next_valid.
    - Go to RUN the cycle after the second word lands.
    - iREQUEST in FILL is ignored (oPIX_VALID=0) and sets oUNDERRUN.
  - RUN: on each cycle with iREQUEST=1:
    - next cycle, oPIXEL=cur[bit] and oPIX_VALID=1 (latency 1 cycle);
    - bit increments;
    - oPIX_COUNT increments.
  - RUN, word boundary (iREQUEST with bit=WORD_WIDTH-1):
    - bit wraps to 0.
    - If next_valid: cur<=next, next_valid<=0.
    - Otherwise: underrun; cur<=0, oUNDERRUN<=1. Pixels of the missing word are output as 0 and the stream stays aligned.
  - RUN, refill: whenever !next_valid, !fetch_pending and !iFIFO_EMPTY, assert oFIFO_RD. Returned data loads next.
    - If return coincides with a boundary that is consuming next: the boundary loads the returned data directly into cur.
  - Frame end: the request for pixel FRAME_PIXELS-1 produces oFRAME_DONE=1 with that pixel.
    - State goes to IDLE; oPIX_COUNT holds FRAME_PIXELS until the next iFRAME_START.
    - No further pops are issued.
    - A fetch in flight lands in next but is discarded on the next iFRAME_START.
- iFRAME_START in any state:
  - Clear buffers, bit, next_valid, oPIX_COUNT, oUNDERRUN; go to FILL.
  - Data returning from a pop issued before the start is discarded.
  - A simultaneous iREQUEST is ignored; start has priority.
- iRST mid-operation: immediate return to reset values. An in-flight FIFO return is ignored.
- oFIFO_RD is never asserted while iFIFO_EMPTY=1, nor while fetch_pending=1.
- Sustains one pixel per clock indefinitely, given the FIFO is non-empty at least once per WORD_WIDTH cycles.

Test Plan:
- Basic unpacking:
  - Stimulus: reset, iFRAME_START, FIFO supplies 16'hA5A5 then 16'h00FF, iREQUEST held high 32 cycles.
  - Required: oPIXEL sequence 1,0,1,0,0,1,0,1,1,0,1,0,0,1,0,1 then eight 1s then eight 0s. oDATA=10'h3FF for each 1; oPIX_VALID high 32 cycles, starting one cycle after the first request.
- Boundary refill:
  - Stimulus: continuous requests with FIFO always non-empty.
  - Required: exactly one oFIFO_RD per 16 pixels; no gap in oPIX_VALID; oUNDERRUN stays 0.
- Underrun:
  - Stimulus: hold iFIFO_EMPTY=1 after the FILL completes, request 48 pixels, then release empty.
  - Required: pixels 32-47 are 0; oUNDERRUN=1 and stays 1; the word popped after release appears at the next boundary.
- Frame end (FRAME_PIXELS=64):
  - Stimulus: stream 64 requests.
  - Required: oFRAME_DONE pulses with pixel 63; oPIX_COUNT=64; state IDLE; further requests give oPIX_VALID=0 and no pops.
- Restart mid-frame:
  - Stimulus: iFRAME_START at pixel 20, coincident with an in-flight pop and iREQUEST.
  - Required: no pixel is output for that request; the stale word is discarded; oPIX_COUNT=0; FILL reissues two pops; the first pixel out is bit 0 of the new word.
- Reset mid-run:
  - Stimulus: iRST for one cycle at pixel 5.
  - Required: all outputs 0 next cycle; no oFIFO_RD until the next iFRAME_START.

Source files
------------

// File: rtl/packed_pixel_reader.sv
// Unpacks 1-bit pixels (LSB first, WORD_WIDTH per word) from an SDRAM read FIFO
// and delivers one pixel per VGA request with one cycle of latency.
module packed_pixel_reader #(
    parameter int WORD_WIDTH   = 16,
    parameter int FRAME_PIXELS = 307200,
    parameter int DATA_WIDTH   = 10
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    input  logic                  iFRAME_START,
    input  logic                  iREQUEST,
    input  logic                  iFIFO_EMPTY,
    output logic                  oFIFO_RD,
    input  logic [WORD_WIDTH-1:0] iFIFO_DATA,
    output logic                  oPIXEL,
    output logic [DATA_WIDTH-1:0] oDATA,
    output logic                  oPIX_VALID,
    output logic                  oFRAME_DONE,
    output logic                  oUNDERRUN,
    output logic [18:0]           oPIX_COUNT
);

    localparam int BIT_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_WIDTH - 1);
    localparam logic [18:0]      LAST_PIX = 19'(FRAME_PIXELS - 1);

    logic [1:0]            state_reg;
    logic [WORD_WIDTH-1:0] cur_word_reg;
    logic [WORD_WIDTH-1:0] next_word_reg;
    logic                  next_valid_reg;
    logic [BIT_W-1:0]      bit_idx_reg;
    logic                  fetch_pending_reg;
    logic [1:0]            fill_cnt_reg;
    logic                  pixel_reg;
    logic                  pix_valid_reg;
    logic                  frame_done_reg;
    logic                  underrun_reg;
    logic [18:0]           pix_count_reg;

    logic fifo_rd;
    logic at_boundary;
    logic last_pixel;

    assign at_boundary = (bit_idx_reg == LAST_BIT);
    assign last_pixel  = (pix_count_reg == LAST_PIX);

    // Pops are suppressed on reset/start cycles since their data would be discarded,
    // and on the final pixel so no word is stolen from the next frame.
    always_comb begin
        fifo_rd = 1'b0;
        if (!iRST && !iFRAME_START && !iFIFO_EMPTY && !fetch_pending_reg) begin
            case (state_reg)
                ST_FILL: fifo_rd = (fill_cnt_reg < 2'd2);
                ST_RUN:  fifo_rd = !next_valid_reg && !(iREQUEST && last_pixel);
                default: fifo_rd = 1'b0;
            endcase
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_reg         <= ST_IDLE;
            cur_word_reg      <= '0;
            next_word_reg     <= '0;
            next_valid_reg    <= 1'b0;
            bit_idx_reg       <= '0;
            fetch_pending_reg <= 1'b0;
            fill_cnt_reg      <= 2'd0;
            pixel_reg         <= 1'b0;
            pix_valid_reg     <= 1'b0;
            frame_done_reg    <= 1'b0;
            underrun_reg      <= 1'b0;
            pix_count_reg     <= '0;
        end else begin
            pixel_reg         <= 1'b0;
            pix_valid_reg     <= 1'b0;
            frame_done_reg    <= 1'b0;
            fetch_pending_reg <= fifo_rd;
            if (iFRAME_START) begin
                state_reg      <= ST_FILL;
                cur_word_reg   <= '0;
                next_word_reg  <= '0;
                next_valid_reg <= 1'b0;
                bit_idx_reg    <= '0;
                fill_cnt_reg   <= 2'd0;
                underrun_reg   <= 1'b0;
                pix_count_reg  <= '0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (fetch_pending_reg) begin
                            next_word_reg  <= iFIFO_DATA;
                            next_valid_reg <= 1'b1;
                        end
                    end
                    ST_FILL: begin
                        if (iREQUEST)
                            underrun_reg <= 1'b1;
                        if (fifo_rd)
                            fill_cnt_reg <= fill_cnt_reg + 2'd1;
                        if (fetch_pending_reg) begin
                            if (fill_cnt_reg == 2'd1) begin
                                cur_word_reg <= iFIFO_DATA;
                            end else begin
                                next_word_reg  <= iFIFO_DATA;
                                next_valid_reg <= 1'b1;
                                state_reg      <= ST_RUN;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (fetch_pending_reg) begin
                            next_word_reg  <= iFIFO_DATA;
                            next_valid_reg <= 1'b1;
                        end
                        if (iREQUEST) begin
                            pixel_reg     <= cur_word_reg[bit_idx_reg];
                            pix_valid_reg <= 1'b1;
                            pix_count_reg <= pix_count_reg + 19'd1;
                            bit_idx_reg   <= bit_idx_reg + BIT_W'(1);
                            if (last_pixel) begin
                                frame_done_reg <= 1'b1;
                                bit_idx_reg    <= '0;
                                state_reg      <= ST_IDLE;
                            end else if (at_boundary) begin
                                bit_idx_reg <= '0;
                                if (next_valid_reg) begin
                                    cur_word_reg   <= next_word_reg;
                                    next_valid_reg <= 1'b0;
                                end else if (fetch_pending_reg) begin
                                    // Word landing exactly on the boundary bypasses next.
                                    cur_word_reg   <= iFIFO_DATA;
                                    next_valid_reg <= 1'b0;
                                end else begin
                                    // Missing word plays out as black so the stream stays aligned.
                                    cur_word_reg <= '0;
                                    underrun_reg <= 1'b1;
                                end
                            end
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    assign oFIFO_RD    = fifo_rd;
    assign oPIXEL      = pixel_reg;
    assign oDATA       = {DATA_WIDTH{pixel_reg}};
    assign oPIX_VALID  = pix_valid_reg;
    assign oFRAME_DONE = frame_done_reg;
    assign oUNDERRUN   = underrun_reg;
    assign oPIX_COUNT  = pix_count_reg;

endmodule

// File: tb/tb_packed_pixel_reader.sv
// Directed bench for packed_pixel_reader with a 64-pixel frame and a
// one-cycle-latency FIFO model in front of it.
module tb_packed_pixel_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        frame_start = 1'b0;
    logic        request = 1'b0;
    logic        fifo_empty;
    logic        fifo_rd;
    logic [15:0] fifo_data = 16'h0;
    logic        pixel;
    logic [9:0]  data;
    logic        pix_valid;
    logic        frame_done;
    logic        underrun;
    logic [18:0] pix_count;

    logic [15:0] mem [0:63];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic        hold_empty = 1'b0;
    int          pop_cnt = 0;
    int          rd_viol = 0;
    int          assert_cnt = 0;
    int          fail_cnt = 0;

    always #5 clk = ~clk;

    assign fifo_empty = hold_empty || (wr_ptr == rd_ptr);

    packed_pixel_reader #(
        .WORD_WIDTH  (16),
        .FRAME_PIXELS(64),
        .DATA_WIDTH  (10)
    ) dut (
        .iCLK        (clk),
        .iRST        (rst),
        .iFRAME_START(frame_start),
        .iREQUEST    (request),
        .iFIFO_EMPTY (fifo_empty),
        .oFIFO_RD    (fifo_rd),
        .iFIFO_DATA  (fifo_data),
        .oPIXEL      (pixel),
        .oDATA       (data),
        .oPIX_VALID  (pix_valid),
        .oFRAME_DONE (frame_done),
        .oUNDERRUN   (underrun),
        .oPIX_COUNT  (pix_count)
    );

    // FIFO model: data appears the cycle after the pop strobe
    always @(posedge clk) begin
        if (fifo_rd) begin
            pop_cnt <= pop_cnt + 1;
            if (fifo_empty) begin
                rd_viol <= rd_viol + 1;
            end else begin
                fifo_data <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assert_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic [15:0] w);
        mem[wr_ptr] = w;
        wr_ptr++;
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (5) tick();
    endtask

    task automatic req_pix(input int idx, input logic exp_pix, input logic exp_done);
        request = 1'b1;
        tick();
        check("pix_valid", 32'(pix_valid), 32'd1);
        check("pixel", 32'(pixel), 32'(exp_pix));
        check("data", 32'(data), 32'({10{exp_pix}}));
        check("frame_done", 32'(frame_done), 32'(exp_done));
        check("pix_count", 32'(pix_count), 32'(idx + 1));
        $display("pixel %0d: value %0d count %0d", idx, pixel, pix_count);
    endtask

    initial begin
        logic [15:0] w;
        logic [15:0] f1 [0:3];
        logic [15:0] f2 [0:3];
        f1[0] = 16'hA5A5; f1[1] = 16'h00FF; f1[2] = 16'h1234; f1[3] = 16'h8001;
        f2[0] = 16'h0F0F; f2[1] = 16'hFFFF; f2[2] = 16'h0000; f2[3] = 16'hC003;

        // reset state
        push(f1[0]); push(f1[1]); push(f1[2]); push(f1[3]);
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("rst_pixel", 32'(pixel), 32'd0);
        check("rst_data", 32'(data), 32'd0);
        check("rst_valid", 32'(pix_valid), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        check("rst_count", 32'(pix_count), 32'd0);
        check("rst_fifo_rd", 32'(fifo_rd), 32'd0);

        // basic unpacking, boundary refill and frame end
        start_frame();
        check("f1_fill_pops", 32'(pop_cnt), 32'd2);
        for (int i = 0; i < 64; i++) begin
            w = f1[i / 16];
            req_pix(i, w[i % 16], i == 63);
        end
        check("f1_underrun", 32'(underrun), 32'd0);
        check("f1_pops", 32'(pop_cnt), 32'd4);
        push(f2[0]);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("idle_valid", 32'(pix_valid), 32'd0);
            check("idle_count", 32'(pix_count), 32'd64);
        end
        check("idle_pops", 32'(pop_cnt), 32'd4);
        request = 1'b0;

        // underrun while the FIFO is held empty, then recovery at a boundary
        push(f2[1]); push(f2[3]);
        start_frame();
        check("f2_fill_pops", 32'(pop_cnt), 32'd6);
        hold_empty = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (i == 40) hold_empty = 1'b0;
            w = f2[i / 16];
            req_pix(i, w[i % 16], i == 63);
            if (i == 30) check("underrun_pre", 32'(underrun), 32'd0);
            if (i == 32) check("underrun_set", 32'(underrun), 32'd1);
        end
        request = 1'b0;
        check("underrun_sticky", 32'(underrun), 32'd1);
        check("f2_pops", 32'(pop_cnt), 32'd7);

        // restart mid-frame with a pop in flight
        push(16'hAAAA); push(16'h5555); push(16'hDEAD); push(16'h0002); push(16'h8000);
        start_frame();
        check("f3_underrun_clr", 32'(underrun), 32'd0);
        check("f3_fill_pops", 32'(pop_cnt), 32'd9);
        w = 16'hAAAA;
        for (int i = 0; i < 16; i++) req_pix(i, w[i], 1'b0);
        hold_empty = 1'b1;
        w = 16'h5555;
        for (int i = 16; i < 20; i++) begin
            if (i == 19) hold_empty = 1'b0;
            req_pix(i, w[i - 16], 1'b0);
        end
        check("inflight_pop", 32'(pop_cnt), 32'd10);
        frame_start = 1'b1;
        request = 1'b1;
        tick();
        check("restart_valid", 32'(pix_valid), 32'd0);
        check("restart_count", 32'(pix_count), 32'd0);
        check("restart_no_pop", 32'(pop_cnt), 32'd10);
        frame_start = 1'b0;
        request = 1'b0;
        repeat (5) tick();
        check("refill_pops", 32'(pop_cnt), 32'd12);
        w = 16'h0002;
        for (int i = 0; i < 5; i++) req_pix(i, w[i], 1'b0);

        // reset mid-run
        push(16'h0001); push(16'h0000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_pixel", 32'(pixel), 32'd0);
        check("mrst_data", 32'(data), 32'd0);
        check("mrst_valid", 32'(pix_valid), 32'd0);
        check("mrst_done", 32'(frame_done), 32'd0);
        check("mrst_underrun", 32'(underrun), 32'd0);
        check("mrst_count", 32'(pix_count), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("mrst_fifo_rd", 32'(fifo_rd), 32'd0);
            check("mrst_valid_hold", 32'(pix_valid), 32'd0);
        end
        check("mrst_pops", 32'(pop_cnt), 32'd12);
        request = 1'b0;

        // request during FILL is ignored and flags underrun
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        request = 1'b1;
        tick();
        request = 1'b0;
        check("fill_req_underrun", 32'(underrun), 32'd1);
        check("fill_req_valid", 32'(pix_valid), 32'd0);
        repeat (4) tick();
        check("f4_fill_pops", 32'(pop_cnt), 32'd14);
        req_pix(0, 1'b1, 1'b0);
        request = 1'b0;
        tick();

        check("rd_while_empty", 32'(rd_viol), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
